// File: rtl/rr_arb4_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_arb4_sel
//  Description : Four-channel round-robin arbiter with a per-grant burst
//                limit. Drives the 2-bit select of a downstream 4:1 mux and
//                qualifies the muxed word with a valid/ready handshake.
//
//  Ports
//    clk        - single clock, rising edge
//    reset_n    - synchronous active-low reset
//    req[3:0]   - per-channel request (bit i: word present on mux input d<i>)
//    out_ready  - consumer accepts the muxed word this cycle
//    gnt[3:0]   - registered one-hot grant, zero when idle
//    sel[1:0]   - registered binary index of the granted channel (mux s)
//    out_valid  - registered; mux output holds a valid word from channel sel
//
//  Parameters
//    BURST_MAX  - max consecutive transfers per grant, legal range 1..15
//
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb4_sel #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       out_valid
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Widened by one bit so cnt+1 can be compared without wrap.
    localparam logic [4:0] c_burst_max = 5'(BURST_MAX);

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] gnt_q,   gnt_d;
    logic       valid_q, valid_d;

    logic [2:0] w_arb_idle;   // {found, index} scanning from ptr_q
    logic [2:0] w_arb_hand;   // {found, index} scanning from sel_q + 1
    logic [1:0] w_next_ptr;
    logic [4:0] w_cnt_inc;
    logic       w_xfer;
    logic       w_keep;

    // Rotating priority scan: offsets are visited from 3 down to 0 so the
    // lowest offset from p (the highest priority) is the last one written.
    function automatic logic [2:0] f_arb(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        valid_d    = valid_q;

        w_next_ptr = sel_q + 2'd1;
        w_arb_idle = f_arb(req, ptr_q);
        w_arb_hand = f_arb(req, w_next_ptr);
        w_cnt_inc  = {1'b0, cnt_q} + 5'd1;
        w_xfer     = valid_q & out_ready;
        w_keep     = req[sel_q] && (w_cnt_inc < c_burst_max) && (|req);

        case (state_q)
            S_IDLE: begin
                if (w_arb_idle[2]) begin
                    state_d = S_GRANT;
                    sel_d   = w_arb_idle[1:0];
                    gnt_d   = f_onehot(w_arb_idle[1:0]);
                    valid_d = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            S_GRANT: begin
                // Without a transfer everything holds, regardless of req.
                if (w_xfer) begin
                    if (w_keep) begin
                        cnt_d = w_cnt_inc[3:0];
                    end else begin
                        // Grant ends: advance priority past the finishing
                        // channel and hand over at this same edge.
                        ptr_d = w_next_ptr;
                        cnt_d = 4'd0;
                        if (w_arb_hand[2]) begin
                            sel_d   = w_arb_hand[1:0];
                            gnt_d   = f_onehot(w_arb_hand[1:0]);
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            gnt_d   = 4'b0000;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb4_sel
//  Description : Directed self-checking bench for rr_arb4_sel. Instance A
//                uses BURST_MAX=4, instance B uses BURST_MAX=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb4_sel;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rdy_a, val_a;
    logic [3:0] req_a, gnt_a;
    logic [1:0] sel_a;

    logic       rst_b, rdy_b, val_b;
    logic [3:0] req_b, gnt_b;
    logic [1:0] sel_b;

    int errors = 0;
    int checks = 0;

    rr_arb4_sel #(.BURST_MAX(4)) u_dut_a (
        .clk       (clk),
        .reset_n   (rst_a),
        .req       (req_a),
        .out_ready (rdy_a),
        .gnt       (gnt_a),
        .sel       (sel_a),
        .out_valid (val_a)
    );

    rr_arb4_sel #(.BURST_MAX(1)) u_dut_b (
        .clk       (clk),
        .reset_n   (rst_b),
        .req       (req_b),
        .out_ready (rdy_b),
        .gnt       (gnt_b),
        .sel       (sel_b),
        .out_valid (val_b)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {gnt, sel, out_valid}; gnt is derived from the invariant.
    function automatic logic [6:0] f_exp(input logic v, input logic [1:0] s);
        logic [3:0] g;
        g = v ? (4'b0001 << s) : 4'b0000;
        return {g, s, v};
    endfunction

    task automatic chk_a(input string tag, input logic v, input logic [1:0] s);
        logic [6:0] exp;
        exp = f_exp(v, s);
        checks++;
        assert ({gnt_a, sel_a, val_a} === exp) else begin
            errors++;
            $error("FAIL %s: observed gnt/sel/valid=%b/%b/%b expected=%b/%b/%b",
                   tag, gnt_a, sel_a, val_a, exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [1:0] s);
        logic [6:0] exp;
        exp = f_exp(v, s);
        checks++;
        assert ({gnt_b, sel_b, val_b} === exp) else begin
            errors++;
            $error("FAIL %s: observed gnt/sel/valid=%b/%b/%b expected=%b/%b/%b",
                   tag, gnt_b, sel_b, val_b, exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        logic [1:0] burst_seq [13];
        logic [1:0] rot_seq   [6];
        burst_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                      2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        rot_seq   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_a = 1'b0; req_a = 4'b0000; rdy_a = 1'b1;
        rst_b = 1'b0; req_b = 4'b0000; rdy_b = 1'b1;

        // Reset held for two edges.
        step();
        step();
        chk_a("reset_a", 1'b0, 2'd0);
        chk_b("reset_b", 1'b0, 2'd0);

        // Single requester: channel 2 granted one cycle after sampling and
        // kept across the burst boundary since nobody else is asking.
        rst_a = 1'b1;
        req_a = 4'b0100;
        step();
        chk_a("single_grant", 1'b1, 2'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_a("single_hold", 1'b1, 2'd2);
        end

        // Burst limit between channels 0 and 1 (ptr is 3 at this point).
        req_a = 4'b0011;
        for (int i = 0; i < 13; i++) begin
            step();
            chk_a("burst_seq", 1'b1, burst_seq[i]);
        end

        // Backpressure while channel 1 holds a fresh grant (cnt=0).
        rdy_a = 1'b0;
        req_a = 4'b1011; step(); chk_a("bp_freeze0", 1'b1, 2'd1);
        req_a = 4'b0011; step(); chk_a("bp_freeze1", 1'b1, 2'd1);
        req_a = 4'b1011; step(); chk_a("bp_freeze2", 1'b1, 2'd1);
        // cnt must not have moved: three more transfers on channel 1, then
        // the fourth ends the burst and rotates to channel 0.
        rdy_a = 1'b1;
        req_a = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("bp_resume", 1'b1, 2'd1);
        end
        step();
        chk_a("bp_rotate", 1'b1, 2'd0);

        // Drain to idle through channel 3.
        req_a = 4'b1000; step(); chk_a("drain_grant3", 1'b1, 2'd3);
        req_a = 4'b0000; step(); chk_a("drain_idle",   1'b0, 2'd3);
        step();                  chk_a("idle_hold",    1'b0, 2'd3);
        // ptr wrapped to 0, so channel 0 beats channel 1.
        req_a = 4'b0011; step(); chk_a("idle_regrant", 1'b1, 2'd0);

        // Reset in the middle of a grant on channel 2.
        req_a = 4'b0100; step(); chk_a("pre_reset_grant", 1'b1, 2'd2);
        rst_a = 1'b0;
        req_a = 4'b1111; step(); chk_a("mid_reset", 1'b0, 2'd0);
        rst_a = 1'b1;    step(); chk_a("post_reset_grant", 1'b1, 2'd0);
        step();                  chk_a("post_reset_hold",  1'b1, 2'd0);

        // Full contention with BURST_MAX=1: one new grant every cycle.
        rst_b = 1'b1;
        req_b = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_b("rotate_b", 1'b1, rot_seq[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arb4_sel.md
# rr_arb4_sel

Four-channel round-robin arbiter with burst limit that drives the 2-bit select of the 4:1 `mux4` data selector directly downstream. It turns four independent request lines into a registered one-hot grant plus a binary `sel`, and qualifies the muxed word with a valid/ready handshake toward the consumer. Grants rotate fairly. A channel keeps the mux for at most `BURST_MAX` consecutive transfers while other channels wait.

## Interface
- `BURST_MAX`, default 4: maximum consecutive accepted transfers per grant. Legal range is 1..15.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req` input, 4 bits: per-channel request; bit i means channel i has a word on mux input `d<i>`.
- `out_ready` input, 1 bit: consumer can accept the muxed word this cycle.
- `gnt` output, 4 bits: registered one-hot grant; all zeros when idle.
- `sel` output, 2 bits: registered binary index of the granted channel; connects to the mux `s`.
- `out_valid` output, 1 bit: registered; the mux output `y` holds a valid word from channel `sel`.

## Operation
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - `ptr[1:0]`: highest-priority channel for the next arbitration.
  - `cnt[3:0]`: number of transfers accepted in the current grant.
- Transfer happens in any cycle with `out_valid && out_ready`.
- Arbitration:
  - Scan `req` starting at `ptr` and wrap modulo 4: ptr, ptr+1, ptr+2, ptr+3.
  - The first asserted bit wins.
  - The result is a pure function of `req` and `ptr` in that cycle.
- IDLE:
  - If `req == 0`, stay in IDLE; outputs stay at 0.
  - Otherwise, at the edge: go to GRANT, load `sel`/`gnt` with the winner, set `out_valid` to 1, clear `cnt`.
- GRANT, no transfer:
  - `sel`, `gnt` and `out_valid` hold, whatever `req` does.
  - Requesters must keep `req` high until their word transfers. The arbiter ignores changes on the granted bit until then.
- GRANT, transfer, and all of the following hold:
  - `req[sel]` is still 1, `cnt+1 < BURST_MAX`, and at least one channel is requesting.
  - Result: keep the grant and increment `cnt`. `out_valid` stays 1.
- GRANT, transfer, otherwise: end the grant.
  - Set `ptr = sel + 1` (mod 4).
  - Re-arbitrate in the same cycle using the new `ptr` and the current `req`.
  - If there is a winner, load it, clear `cnt`, keep `out_valid` at 1, and stay in GRANT. The granted channel may be the same one if it is the only requester.
  - If there is no winner, go to IDLE with `out_valid = 0` and `gnt = 0`. `sel` holds its last value.
- Invariants:
  - `gnt == (1 << sel)` whenever `out_valid` is 1.
  - `gnt == 0` whenever `out_valid` is 0.
- `cnt` never exceeds `BURST_MAX - 1`.

## Timing
- Reset values: `gnt = 0000`, `sel = 00`, `out_valid = 0`, `ptr = 00`, `cnt = 0`, FSM in IDLE. Channel 0 therefore has first priority after reset.
- Reset in the middle of a grant takes effect at the next rising edge. Any in-flight word is dropped with no transfer. Reset has priority over all other events.
- Request-to-valid latency: `req` sampled high at edge n gives `gnt`/`sel`/`out_valid` valid after edge n (one cycle from assertion).
- Handover: the new grant loads at the same edge as the final transfer of the old one. There is no bubble cycle with continuous requests and `out_ready = 1`.
- Throughput: one transfer per cycle while `out_ready = 1`.
- Backpressure: `out_ready = 0` freezes all state except reset.
- All outputs are registered. There is no combinational path from `req` or `out_ready` to any output.

## Test plan
- Reset then single request:
  - Stimulus: hold `reset_n = 0` for 2 cycles, release, set `req = 0100`, `out_ready = 1`.
  - Required: one cycle after `req` is sampled, `sel = 10`, `gnt = 0100`, `out_valid = 1`.
  - Required: `gnt`/`sel` stay there for 4 transfers (BURST_MAX=4), then stay there again because channel 2 is the only requester.
- Full contention:
  - Stimulus: `req = 1111`, `out_ready = 1`, BURST_MAX=1.
  - Required: `sel` sequence 0,1,2,3,0,... with one new grant per cycle and no idle cycles.
- Burst limit:
  - Stimulus: `req = 0011`, BURST_MAX=4, `out_ready = 1`.
  - Required: `sel = 0` for exactly 4 cycles, then `sel = 1` for 4 cycles, then back to `sel = 0`.
- Backpressure:
  - Stimulus: while `sel = 01` and `out_valid = 1`, drop `out_ready` for 3 cycles and toggle `req[3]`.
  - Required: `sel`, `gnt`, `out_valid` and `cnt` are unchanged for all 3 cycles; the transfer counts only when `out_ready` returns to 1.
- Drain to idle:
  - Stimulus: `req = 1000`, then drop `req` to 0000 in the same cycle as the transfer.
  - Required: next cycle `out_valid = 0`, `gnt = 0000`, `sel` holds `11`; a later `req = 0001` gives `sel = 00` (ptr = 0).
- Reset mid-grant:
  - Stimulus: assert `reset_n = 0` for 1 cycle while `sel = 10` and `out_valid = 1`.
  - Required: after that edge, all outputs are at their reset values; with `req = 1111`, the next grant is channel 0.
